pwm_duty_ramp: RTL
==================

Name: pwm_duty_ramp

Overview:
Upstream duty-cycle sequencer for the 4-bit PWM stage; drives the PWM duty input with a triangular up/down ("breathing") ramp.
- Duty changes only at PWM period boundaries, so the PWM never sees a mid-period update.
- Configurable steps per PWM period and dwell at top/bottom.
- Flags completion of each full triangle.

Parameters:
DUTY_W, 4, width of duty output; DUTY_MAX = 2^DUTY_W-1
STEP_PERIODS, 16, PWM periods per duty step (>=1)
HOLD_STEPS, 8, step intervals dwelled at top and at bottom (0 = no dwell)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous reset, active-low
en  in  1  run request; level-sensitive
period_end  in  1  one-clk pulse from PWM stage at its counter wrap
duty_out  out  DUTY_W  duty value to PWM stage PWM_in
dir_out  out  1  1 = ramping up or holding high, 0 otherwise
cycle_done  out  1  one-clk pulse at end of each full triangle

Behaviour:
- Reset (rst_n=0 at clk edge):
  - state=IDLE, duty_out=0, dir_out=0, cycle_done=0.
  - All counters 0.
  - Reset mid-ramp takes effect on the next edge regardless of period_end.
- step strobe: internal.
  - Period counter increments on each period_end while state!=IDLE.
  - step=1 when period_end=1 and counter==STEP_PERIODS-1; the counter then wraps to 0.
  - Entering RAMP_UP from IDLE clears the counter.
- All outputs are registered; duty_out updates on the clk edge where step=1 (visible the cycle after the period_end pulse).
- States and transitions:
  - IDLE:
    - duty_out=0.
    - en=1 -> RAMP_UP next cycle, dir_out<=1.
  - RAMP_UP, on step:
    - duty_out<=duty_out+1.
    - If new value==DUTY_MAX: go HOLD_HIGH (HOLD_STEPS>0) or RAMP_DOWN (HOLD_STEPS=0, dir_out<=0).
  - HOLD_HIGH:
    - Hold counter counts steps.
    - After HOLD_STEPS steps: go RAMP_DOWN, dir_out<=0, hold counter cleared.
  - RAMP_DOWN, on step:
    - duty_out<=duty_out-1.
    - If new value==0: go HOLD_LOW (HOLD_STEPS>0); otherwise the cycle ends.
  - HOLD_LOW: after HOLD_STEPS steps, the cycle ends.
- Cycle end:
  - cycle_done=1 for exactly one clk (the edge after the completing step).
  - State goes RAMP_UP with dir_out<=1 if en=1, else IDLE.
- Duty arithmetic:
  - Unsigned, DUTY_W bits.
  - Never wraps: no increment past DUTY_MAX, no decrement below 0.
- en deassert mid-ramp:
  - Abort is deferred to the next period_end (not only step).
  - On that edge: duty_out<=0, dir_out<=0, state<=IDLE, no cycle_done.
  - en re-asserted before that period_end cancels the abort.
- Simultaneous events: step coinciding with the abort period_end is ignored; the abort wins.
- Full triangle length: 2*DUTY_MAX + 2*HOLD_STEPS steps, each step = STEP_PERIODS PWM periods.

Decomposition:
- Shared package pwm_pkg:
  - DUTY_W default.
  - State encodings IDLE/RAMP_UP/HOLD_HIGH/RAMP_DOWN/HOLD_LOW as localparams.
  - DUTY_MAX derivation.
- One sub-module, pwm_step_timer: period_end counter producing the step strobe; parameter STEP_PERIODS; inputs clk, rst_n, clr, period_end; output step.
- FSM, duty register and hold counter live in pwm_duty_ramp.

Test Plan:
1. Reset: rst_n=0 for 3 clk while en=1 and period_end pulsing -> duty_out=0, dir_out=0, cycle_done=0 throughout.
2. Full ramp, STEP_PERIODS=1, HOLD_STEPS=0:
   - Stimulus: en=1, period_end every 8 clk.
   - Required: duty_out 0->15 in 15 steps, then 15->0.
   - Required: dir_out falls on the edge duty reaches 15.
   - Required: cycle_done pulses once after 30 period_ends; ramp restarts.
3. Dwell, STEP_PERIODS=2, HOLD_STEPS=3 -> duty_out held at 15 for 6 period_ends and at 0 for 6 period_ends; total cycle = 72 period_ends.
4. Abort:
   - Stimulus: drop en with duty_out=7 ramping up.
   - Required: duty_out stays 7 until next period_end, then 0, state IDLE, no cycle_done.
   - Required: re-raising en restarts from 0.
5. Abort cancel: drop en for 2 clk between period_ends -> no abort, ramp continues uninterrupted.
6. Reset mid-ramp: rst_n=0 for 1 clk at duty_out=12 in RAMP_DOWN -> duty_out=0 next edge; with en=1, ramp restarts upward and period counter starts from 0.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM duty ramp sequencer: default duty width,
// state encodings and the duty ceiling helper.
package pwm_pkg;

    localparam int DUTY_W_DEF = 4;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_RAMP_UP   = 3'd1;
    localparam logic [2:0] ST_HOLD_HIGH = 3'd2;
    localparam logic [2:0] ST_RAMP_DOWN = 3'd3;
    localparam logic [2:0] ST_HOLD_LOW  = 3'd4;

    typedef enum logic [2:0] {
        IDLE      = ST_IDLE,
        RAMP_UP   = ST_RAMP_UP,
        HOLD_HIGH = ST_HOLD_HIGH,
        RAMP_DOWN = ST_RAMP_DOWN,
        HOLD_LOW  = ST_HOLD_LOW
    } state_t;

    function automatic int duty_max(input int w);
        return (1 << w) - 1;
    endfunction

endpackage

// File: rtl/pwm_step_timer.sv
// Counts PWM period boundaries and raises a one-cycle step strobe every
// STEP_PERIODS of them; clr holds the count at zero and masks the strobe.
module pwm_step_timer #(
    parameter int STEP_PERIODS = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic period_end,
    output logic step
);

    localparam int CW = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(STEP_PERIODS - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign step = period_end && !clr && (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (period_end) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pwm_duty_ramp.sv
// Triangular "breathing" duty sequencer feeding the PWM stage; duty only
// moves on step strobes, which are themselves aligned to PWM period ends.
module pwm_duty_ramp
    import pwm_pkg::*;
#(
    parameter int DUTY_W       = DUTY_W_DEF,
    parameter int STEP_PERIODS = 16,
    parameter int HOLD_STEPS   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              period_end,
    output logic [DUTY_W-1:0] duty_out,
    output logic              dir_out,
    output logic              cycle_done,
    output logic [2:0]        state_o
);

    localparam logic [DUTY_W-1:0] DUTY_MAX = DUTY_W'(duty_max(DUTY_W));
    localparam int HW = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'((HOLD_STEPS > 0) ? HOLD_STEPS - 1 : 0);

    state_t            state_q;
    logic [DUTY_W-1:0] duty_q;
    logic              dir_q;
    logic              done_q;
    logic [HW-1:0]     hold_q;

    logic              step;
    logic              abort;
    logic [DUTY_W-1:0] up_next;
    logic [DUTY_W-1:0] dn_next;

    pwm_step_timer #(
        .STEP_PERIODS(STEP_PERIODS)
    ) u_step_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (state_q == IDLE),
        .period_end(period_end),
        .step      (step)
    );

    // A dropped en is only acted on at a period boundary, so the PWM never
    // sees a mid-period change; this outranks any step on the same edge.
    assign abort   = (state_q != IDLE) && period_end && !en;
    assign up_next = (duty_q == DUTY_MAX) ? duty_q : duty_q + DUTY_W'(1);
    assign dn_next = (duty_q == '0) ? duty_q : duty_q - DUTY_W'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            duty_q  <= '0;
            dir_q   <= 1'b0;
            done_q  <= 1'b0;
            hold_q  <= '0;
        end else begin
            done_q <= 1'b0;
            if (abort) begin
                state_q <= IDLE;
                duty_q  <= '0;
                dir_q   <= 1'b0;
                hold_q  <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        duty_q <= '0;
                        hold_q <= '0;
                        if (en) begin
                            state_q <= RAMP_UP;
                            dir_q   <= 1'b1;
                        end
                    end
                    RAMP_UP: if (step) begin
                        duty_q <= up_next;
                        if (up_next == DUTY_MAX) begin
                            if (HOLD_STEPS > 0) begin
                                state_q <= HOLD_HIGH;
                            end else begin
                                state_q <= RAMP_DOWN;
                                dir_q   <= 1'b0;
                            end
                        end
                    end
                    HOLD_HIGH: if (step) begin
                        if (hold_q == HOLD_LAST) begin
                            hold_q  <= '0;
                            state_q <= RAMP_DOWN;
                            dir_q   <= 1'b0;
                        end else begin
                            hold_q <= hold_q + HW'(1);
                        end
                    end
                    RAMP_DOWN: if (step) begin
                        duty_q <= dn_next;
                        if (dn_next == '0) begin
                            if (HOLD_STEPS > 0) begin
                                state_q <= HOLD_LOW;
                            end else begin
                                done_q  <= 1'b1;
                                state_q <= en ? RAMP_UP : IDLE;
                                dir_q   <= en;
                            end
                        end
                    end
                    HOLD_LOW: if (step) begin
                        if (hold_q == HOLD_LAST) begin
                            hold_q  <= '0;
                            done_q  <= 1'b1;
                            state_q <= en ? RAMP_UP : IDLE;
                            dir_q   <= en;
                        end else begin
                            hold_q <= hold_q + HW'(1);
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign duty_out   = duty_q;
    assign dir_out    = dir_q;
    assign cycle_done = done_q;
    assign state_o    = state_q;

endmodule
